p521_reduce: RTL and testbench
==============================

Name: p521_reduce

Overview:
Downstream stage of the 521x521 schoolbook multiplier. Consumes the 1042-bit product and reduces it modulo the Mersenne prime P = 2^521-1 to a 521-bit residue, for P-521 field arithmetic. The reduction is limb-serial: it sums the low and high halves one limb per cycle, folds the carry, then optionally canonicalises. Valid/ready handshakes sit on both sides, so a wrapper can stall it.

Parameters:
WIDTH, 521, field width; the modulus is 2^WIDTH-1 and the input is 2*WIDTH bits.
LIMB, 64, adder slice width per ADD cycle; NLIMB = ceil(WIDTH/LIMB) = 9 at defaults.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a product.
in_data  input  2*WIDTH  product c; lo = c[WIDTH-1:0], hi = c[2*WIDTH-1:WIDTH].
out_valid  output  1  out_data holds a result.
out_ready  input  1  consumer accepts the result.
out_data  output  WIDTH  residue.

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE, in_ready=1, out_valid=0, out_data=0, limb counter=0, carry=0, internal lo/hi/sum registers=0.
- Reset asserted mid-operation aborts the operation and emits no result.
- States: IDLE -> ADD -> FOLD -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch lo and hi, clear carry and limb counter, go to ADD.
  - With in_valid=0: stay in IDLE.
- ADD: in_ready=0, one limb per cycle for k = 0..NLIMB-1.
  - sum[k] = lo[k] + hi[k] + carry; the new carry is the bit above the limb.
  - The top limb is WIDTH - (NLIMB-1)*LIMB bits wide (9 at defaults); its carry-out is s[WIDTH].
  - Leave ADD after limb NLIMB-1, holding s = lo + hi with s < 2^(WIDTH+1).
- FOLD: one cycle.
  - r = s[WIDTH-1:0] + s[WIDTH].
  - The bound s <= 2P gives r <= P, so no second fold is needed.
  - Register r into out_data, set out_valid=1, go to DONE.
  - Canonicalisation depends on the optional feature below.
- DONE:
  - out_valid=1; out_data is held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - in_ready=0 throughout DONE; in_valid is ignored in DONE.
- Latency: input handshake at edge E0; ADD occupies edges E1..E9; FOLD at E10; out_valid is high starting at edge E10.
  - With out_ready held high, out_valid is a single-cycle pulse, deasserted at E11.
  - Back-to-back throughput: one result per 12 cycles (in_ready=1 again after E11, next handshake at E12 at the earliest).
- Simultaneous events:
  - An out_ready handshake and in_valid on the same edge: out_ready is honoured; in_valid waits for the IDLE cycle.
  - in_valid high outside IDLE is ignored; in_data is sampled only on the IDLE handshake edge.
- Arithmetic:
  - Unsigned arithmetic throughout.
  - in_data may be any 2*WIDTH-bit value, including values above (P-1)^2; the result is still congruent mod P.

Optional Feature:
Macro P521_FULL_REDUCE_EN.
- Defined: FOLD compares r with all-ones (r == P) and writes 0 instead, so out_data is canonical in [0, P-1].
- Undefined: no compare; out_data = r in [0, P] (lazy reduction, value P allowed). Latency is identical in both builds.

Test Plan:
- in_data=0 -> out_data=0; out_valid rises at E10 after the handshake edge.
- in_data=2^521 (hi=1, lo=0) -> out_data=1.
- in_data=2^521-1 (lo=P, hi=0) -> out_data=0 with P521_FULL_REDUCE_EN defined; out_data=2^521-1 without it.
- in_data=2^1042-1 (lo=hi=P, s=2^522-2) -> out_data=0 defined, P undefined; exercises the fold path.
- in_data=(P-1)^2 -> out_data=1; then 200 random products compared against a c mod P model, with out_ready randomly low.
  - While out_ready=0: out_data is stable and in_ready=0.
- rst pulsed high during ADD limb 4 -> out_valid stays 0, state returns to IDLE, in_ready=1 immediately.
  - The next product, input 2^521+5, yields out_data=6.

Source files
------------

// File: rtl/p521_reduce.sv
// Limb-serial reduction of a 1042-bit product modulo P = 2^521-1.
// Define P521_FULL_REDUCE_EN for canonical output in [0, P-1]; otherwise [0, P].
module p521_reduce #(
  parameter int WIDTH = 521,
  parameter int LIMB  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int NLIMB = (WIDTH + LIMB - 1) / LIMB;
  localparam int PADW  = NLIMB * LIMB;
  localparam int KW    = $clog2(NLIMB + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    FOLD,
    DONE
  } state_t;

  state_t          state;
  logic [PADW-1:0] lo;
  logic [PADW-1:0] hi;
  logic [PADW-1:0] sum;
  logic            carry;
  logic [KW-1:0]   k;
  logic [LIMB:0]   limb_sum;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_fin;

  // One limb of lo + hi + carry; operands are zero-padded above WIDTH
  always_comb begin
    limb_sum = {1'b0, lo[k*LIMB +: LIMB]}
             + {1'b0, hi[k*LIMB +: LIMB]}
             + {{LIMB{1'b0}}, carry};
  end

  // End-around fold: bits above WIDTH (at most s[WIDTH]) add back in
  always_comb begin
    r = sum[WIDTH-1:0] + WIDTH'(sum[PADW-1:WIDTH]);
`ifdef P521_FULL_REDUCE_EN
    r_fin = (&r) ? '0 : r;
`else
    r_fin = r;
`endif
  end

  // Control FSM with registered handshake outputs and datapath state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      k         <= '0;
      carry     <= 1'b0;
      lo        <= '0;
      hi        <= '0;
      sum       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            lo       <= PADW'(in_data[WIDTH-1:0]);
            hi       <= PADW'(in_data[2*WIDTH-1:WIDTH]);
            carry    <= 1'b0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          sum[k*LIMB +: LIMB] <= limb_sum[LIMB-1:0];
          carry <= limb_sum[LIMB];
          k     <= k + 1'b1;
          if (k == KW'(NLIMB - 1)) begin
            state <= FOLD;
          end
        end
        FOLD: begin
          out_data  <= r_fin;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p521_reduce.sv
// Scoreboard bench for p521_reduce: directed corners, random products,
// output backpressure and a mid-operation reset.
module tb_p521_reduce;

  localparam int W = 521;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;

  p521_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp;
    bit           lazy_ok;
  } sb_t;

  sb_t            sb[$];
  int             n_chk  = 0;
  int             n_pass = 0;
  int             n_fail = 0;
  bit             rand_mode = 1'b0;
  logic [W-1:0]   held;
  bit             hold_v = 1'b0;

  logic [W-1:0]   P;
  logic [2*W-1:0] P_WIDE;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Residue model: exact c mod P via wide modulus
  function automatic logic [W-1:0] model(input logic [2*W-1:0] c);
    logic [2*W-1:0] m;
    m = c % P_WIDE;
    return m[W-1:0];
  endfunction

  task automatic send(input logic [2*W-1:0] c, input logic [W-1:0] exp,
                      input bit lazy_ok);
    sb_t e;
    int  t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 1'b0, 1'b1);
    end else begin
      in_valid = 1'b1;
      in_data  = c;
      e.exp     = exp;
      e.lazy_ok = lazy_ok;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_data = '0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", W'(sb.size()), '0);
  endtask

  // Output monitor: randomises out_ready, pops on handshake, checks hold
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stable_data", out_data, held);
        chk("in_ready_done", W'(in_ready), '0);
      end
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        hold_v = 1'b0;
        if (sb.size() == 0) begin
          chk("spurious_out", W'(out_valid), '0);
        end else begin
          sb_t e;
          logic [W-1:0] got;
          e = sb.pop_front();
          got = (e.lazy_ok && out_data == P) ? '0 : out_data;
          chk("result", got, e.exp);
        end
      end else if (out_valid) begin
        held   = out_data;
        hold_v = 1'b1;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    logic [2*W-1:0] c;
    logic [W-1:0]   pm1;
    logic [W-1:0]   lazy_p;
    P      = '1;
    P_WIDE = {{W{1'b0}}, P};
`ifdef P521_FULL_REDUCE_EN
    lazy_p = '0;
`else
    lazy_p = P;
`endif

    #12;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b0;

    // Zero input with latency check: out_valid rises at E10
    send('0, '0, 1'b0);
    repeat (9) @(posedge clk);
    #1 chk("lat_e9_low", W'(out_valid), '0);
    @(posedge clk);
    #1 chk("lat_e10_high", W'(out_valid), W'(1));
    @(posedge clk);
    #1 chk("lat_e11_low", W'(out_valid), '0);

    c = '0;
    c[W] = 1'b1;
    send(c, W'(1), 1'b0);
    send({{W{1'b0}}, P}, lazy_p, 1'b0);
    send('1, lazy_p, 1'b0);
    pm1 = P - 1'b1;
    c = {{W{1'b0}}, pm1} * {{W{1'b0}}, pm1};
    send(c, W'(1), 1'b0);
    drain();

    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      c = '0;
      for (int j = 0; j < 33; j++) c = (c << 32) | 2*W'($urandom);
      case (i % 10)
        3: c[W-1:0] = P;
        6: c[2*W-1:W] = P;
        default: ;
      endcase
      send(c, model(c), 1'b1);
    end
    drain();
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during ADD limb 4 aborts without a result
    c = '0;
    c[W] = 1'b1;
    c[3:0] = 4'd9;
    send(c, W'(10), 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_out_valid", W'(out_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) chk("abort_no_out", W'(out_valid), '0);
    end
    chk("abort_idle_ready", W'(in_ready), W'(1));

    c = '0;
    c[W] = 1'b1;
    c[2:0] = 3'd5;
    send(c, W'(6), 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
